// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, PC step and
// instruction field bounds used to slice opcode/function out of a fetched word.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register: async reset load, sequential +PC_STEP increment,
// and a redirect load that always wins over the increment.
module pc_counter
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_load,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // The 32-bit add wraps naturally, so 32'hFFFF_FFFC steps to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues one memory request at a
// time, holds the returned word for the consumer, and handles redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pcLoad,
    input  logic [31:0] pcTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instrOut,
    output logic [5:0]  opOut,
    output logic [5:0]  funcOut,
    output logic [31:0] pcOut
);

    state_t      r_state;
    state_t      w_next;
    logic        r_discard;
    logic        w_discard_nxt;
    logic        w_fire;
    logic        w_addr_load;
    logic [31:0] w_pc;
    logic [31:0] w_pc_redir;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pcout;

    pc_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_fire),
        .i_load   (pcLoad),
        .i_target (pcTarget),
        .o_pc     (w_pc)
    );

    // A redirect in the same cycle as an issue must already point at the target.
    assign w_pc_redir = pcLoad ? pcTarget : w_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_discard <= w_discard_nxt;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_discard_nxt = r_discard;
        w_fire        = 1'b0;
        w_addr_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next      = WAIT;
                    w_addr_load = 1'b1;
                end
            end
            WAIT: begin
                if (imemAck) begin
                    if (r_discard || pcLoad) begin
                        // Stale response: drop it and reissue from the redirected PC.
                        w_discard_nxt = 1'b0;
                        if (en) begin
                            w_addr_load = 1'b1;
                        end else begin
                            w_next = IDLE;
                        end
                    end else begin
                        w_fire = 1'b1;
                        w_next = HOLD;
                    end
                end else if (pcLoad) begin
                    w_discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (pcLoad || instrReady) begin
                    if (en) begin
                        w_next      = WAIT;
                        w_addr_load = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: begin
                w_next        = IDLE;
                w_discard_nxt = 1'b0;
            end
        endcase
    end

    // Request address is registered so it stays put while a redirect moves the PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= RESET_PC;
        end else if (w_addr_load) begin
            r_addr <= w_pc_redir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= 32'h0;
            r_pcout <= 32'h0;
        end else if (w_fire) begin
            r_instr <= imemRdata;
            r_pcout <= w_pc;
        end
    end

    assign imemReq    = (r_state == WAIT);
    assign imemAddr   = r_addr;
    assign instrValid = (r_state == HOLD);
    assign instrOut   = r_instr;
    assign opOut      = r_instr[OP_MSB:OP_LSB];
    assign funcOut    = r_instr[FUNC_MSB:FUNC_LSB];
    assign pcOut      = r_pcout;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench: a memory responder checks request addresses, a monitor
// checks every accepted instruction against hand-computed expectations.
module tb_instr_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  func;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pcLoad;
    logic [31:0] pcTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrOut;
    logic [5:0]  opOut;
    logic [5:0]  funcOut;
    logic [31:0] pcOut;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    bit          stray_ack = 1'b0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pcLoad     (pcLoad),
        .pcTarget   (pcTarget),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemRdata  (imemRdata),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instrOut   (instrOut),
        .opOut      (opOut),
        .funcOut    (funcOut),
        .pcOut      (pcOut)
    );

    always #5 clk = ~clk;

    // Memory contents: {addr[7:2]^6'h2A, 20'hABCDE, addr[7:2]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        return {idx ^ 6'h2A, 20'hABCDE, idx};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [5:0] op, input logic [5:0] func);
        exp_t e;
        e.pc = pc; e.instr = instr; e.op = op; e.func = func;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Responder: acks two cycles after each request is first seen.
    initial begin : responder
        bit          busy;
        int          cnt;
        logic [31:0] req_addr;
        busy = 1'b0; cnt = 0; req_addr = 32'h0;
        imemAck = 1'b0; imemRdata = 32'h0;
        forever begin
            @(negedge clk);
            imemAck = 1'b0;
            if (stray_ack) begin
                imemAck   = 1'b1;
                imemRdata = 32'hDEAD_BEEF;
                stray_ack = 1'b0;
                busy      = 1'b0;
            end else if (!rst) begin
                busy = 1'b0;
            end else if (imemReq) begin
                if (!busy) begin
                    busy = 1'b1; cnt = 0; req_addr = imemAddr;
                    if (addr_q.size() == 0) begin
                        timeout("unexpected_request");
                    end else begin
                        chk("req_addr", imemAddr, addr_q.pop_front());
                    end
                end else begin
                    cnt++;
                    chk("req_stable", imemAddr, req_addr);
                end
                if (cnt == 2) begin
                    imemAck   = 1'b1;
                    imemRdata = mem_word(req_addr);
                    busy      = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && instrValid && instrReady) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    timeout("unexpected_instr");
                end else begin
                    e = exp_q.pop_front();
                    chk("pcOut", pcOut, e.pc);
                    chk("instrOut", instrOut, e.instr);
                    chk("opOut", {26'h0, opOut}, {26'h0, e.op});
                    chk("funcOut", {26'h0, funcOut}, {26'h0, e.func});
                end
            end
        end
    end

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_cnt < n && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (acc_cnt < n) timeout("wait_accept");
    endtask

    task automatic wait_req(input logic [31:0] a);
        int k = 0;
        while (!(imemReq === 1'b1 && imemAddr === a) && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (!(imemReq === 1'b1 && imemAddr === a)) timeout("wait_request");
    endtask

    task automatic wait_valid();
        int k = 0;
        while (instrValid !== 1'b1 && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (instrValid !== 1'b1) timeout("wait_valid");
    endtask

    task automatic apply_reset();
        rst = 1'b0; en = 1'b0; pcLoad = 1'b0; instrReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int          base;
        logic [31:0] cap_instr, cap_pc;
        rst = 1'b0; en = 1'b0; pcLoad = 1'b0; pcTarget = 32'h0; instrReady = 1'b0;
        #3;
        chk("rst_imemReq", {31'h0, imemReq}, 32'h0);
        chk("rst_imemAddr", imemAddr, 32'h0);
        chk("rst_instrValid", {31'h0, instrValid}, 32'h0);
        chk("rst_instrOut", instrOut, 32'h0);
        chk("rst_opOut", {26'h0, opOut}, 32'h0);
        chk("rst_funcOut", {26'h0, funcOut}, 32'h0);
        chk("rst_pcOut", pcOut, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Sequential fetch, then backpressure on 0xC.
        addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_q.push_back(mk(32'h0, 32'hAAAF_3780, 6'h2A, 6'h00));
        exp_q.push_back(mk(32'h4, 32'hAEAF_3781, 6'h2B, 6'h01));
        exp_q.push_back(mk(32'h8, 32'hA2AF_3782, 6'h28, 6'h02));
        exp_q.push_back(mk(32'hC, 32'hA6AF_3783, 6'h29, 6'h03));
        en = 1'b1; instrReady = 1'b1;
        wait_acc(3);
        instrReady = 1'b0;
        wait_valid();
        cap_instr = instrOut; cap_pc = pcOut;
        chk("bp_pc", cap_pc, 32'hC);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_instr", instrOut, cap_instr);
            chk("bp_pcOut", pcOut, cap_pc);
            chk("bp_valid", {31'h0, instrValid}, 32'h1);
            chk("bp_noreq", {31'h0, imemReq}, 32'h0);
        end
        addr_q.push_back(32'h10);
        exp_q.push_back(mk(32'h10, 32'hBAAF_3784, 6'h2E, 6'h04));
        instrReady = 1'b1;
        wait_acc(4);
        en = 1'b0;
        wait_acc(5);
        repeat (4) @(posedge clk);

        // Redirect while the 0x8 response is outstanding.
        apply_reset();
        base = acc_cnt;
        addr_q = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_q.push_back(mk(32'h0, 32'hAAAF_3780, 6'h2A, 6'h00));
        exp_q.push_back(mk(32'h4, 32'hAEAF_3781, 6'h2B, 6'h01));
        exp_q.push_back(mk(32'h100, 32'hAAAF_3780, 6'h2A, 6'h00));
        en = 1'b1; instrReady = 1'b1;
        wait_req(32'h8);
        pcLoad = 1'b1; pcTarget = 32'h100;
        @(posedge clk); #1 pcLoad = 1'b0;
        wait_req(32'h100);
        en = 1'b0;
        wait_acc(base + 3);
        repeat (4) @(posedge clk);

        // Redirect in HOLD with instrReady in the same cycle.
        apply_reset();
        base = acc_cnt;
        addr_q = '{32'h0, 32'h200};
        exp_q.push_back(mk(32'h0, 32'hAAAF_3780, 6'h2A, 6'h00));
        exp_q.push_back(mk(32'h200, 32'hAAAF_3780, 6'h2A, 6'h00));
        en = 1'b1;
        wait_valid();
        pcLoad = 1'b1; pcTarget = 32'h200; instrReady = 1'b1;
        @(posedge clk); #1 pcLoad = 1'b0;
        chk("redir_valid_clr", {31'h0, instrValid}, 32'h0);
        chk("redir_req", {31'h0, imemReq}, 32'h1);
        chk("redir_addr", imemAddr, 32'h200);
        en = 1'b0;
        wait_acc(base + 2);
        repeat (4) @(posedge clk);

        // Redirect in IDLE to the top of memory; PC wraps to 0.
        apply_reset();
        base = acc_cnt;
        pcLoad = 1'b1; pcTarget = 32'hFFFF_FFFC;
        @(posedge clk); #1 pcLoad = 1'b0;
        chk("idle_load_noreq", {31'h0, imemReq}, 32'h0);
        addr_q = '{32'hFFFF_FFFC, 32'h0};
        exp_q.push_back(mk(32'hFFFF_FFFC, 32'h56AF_37BF, 6'h15, 6'h3F));
        exp_q.push_back(mk(32'h0, 32'hAAAF_3780, 6'h2A, 6'h00));
        en = 1'b1; instrReady = 1'b1;
        wait_req(32'h0);
        en = 1'b0;
        wait_acc(base + 2);
        repeat (4) @(posedge clk);

        // Reset mid-request, stray ack right after release.
        apply_reset();
        base = acc_cnt;
        addr_q = '{32'h0};
        en = 1'b1; instrReady = 1'b1;
        wait_req(32'h0);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        chk("async_rst_req", {31'h0, imemReq}, 32'h0);
        chk("async_rst_addr", imemAddr, 32'h0);
        chk("async_rst_valid", {31'h0, instrValid}, 32'h0);
        addr_q.push_back(32'h0);
        exp_q.push_back(mk(32'h0, 32'hAAAF_3780, 6'h2A, 6'h00));
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; stray_ack = 1'b1;
        @(posedge clk); #1;
        wait_req(32'h0);
        en = 1'b0;
        wait_acc(base + 1);
        repeat (6) @(posedge clk);

        chk("addr_q_empty", addr_q.size(), 32'h0);
        chk("exp_q_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  fetch enable; low blocks issue of new memory requests.
REQ-005 Port: pcLoad  input  1  redirect strobe (branch/jump).
REQ-006 Port: pcTarget  input  32  redirect target address.
REQ-007 Port: imemReq  output  1  instruction-memory request.
REQ-008 Port: imemAddr  output  32  request address.
REQ-009 Port: imemAck  input  1  memory response valid; single-cycle pulse.
REQ-010 Port: imemRdata  input  32  instruction word, valid when imemAck high.
REQ-011 Port: instrValid  output  1  fetched instruction available to consumer.
REQ-012 Port: instrReady  input  1  consumer accepts instruction.
REQ-013 Port: instrOut  output  32  fetched instruction word.
REQ-014 Port: opOut  output  6  instrOut[31:26].
REQ-015 Port: funcOut  output  6  instrOut[5:0].
REQ-016 Port: pcOut  output  32  address of instruction on instrOut.

Function
REQ-017 States SHALL be IDLE, WAIT, HOLD; at most one memory request outstanding.
REQ-018 IDLE: en high -> WAIT; imemReq high with imemAddr=PC from the next cycle.
REQ-019 WAIT: imemReq and imemAddr SHALL stay stable until imemAck; no withdrawal.
REQ-020 WAIT, imemAck, no pending discard: latch imemRdata into instrOut/opOut/funcOut, pcOut<=PC, PC<=PC+4, instrValid=1 next cycle, -> HOLD (ack-to-valid latency 1 cycle).
REQ-021 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-022 HOLD: instrOut/opOut/funcOut/pcOut/instrValid SHALL stay stable until instrValid&instrReady.
REQ-023 HOLD accept with en high -> WAIT, new request next cycle (no bubble beyond 1 cycle); en low -> IDLE, instrValid=0.
REQ-024 pcLoad SHALL have priority: PC<=pcTarget in every state.
REQ-025 pcLoad in IDLE: PC updated, state per en.
REQ-026 pcLoad in HOLD: instrValid cleared next cycle, held instruction dropped unless instrReady same cycle (then counted accepted); -> WAIT with imemAddr=pcTarget.
REQ-027 pcLoad in WAIT without imemAck: set discard flag; outstanding request completes at old address; its data SHALL be dropped (instrValid stays 0); then new request at pcTarget.
REQ-028 pcLoad coincident with imemAck in WAIT: data dropped, new request at pcTarget next cycle.
REQ-029 en low in WAIT: outstanding request completes normally to HOLD; no further issue.
REQ-030 imemAck outside WAIT SHALL be ignored.

Reset
REQ-031 rst low SHALL immediately force: state IDLE, PC=RESET_PC, imemReq=0, imemAddr=RESET_PC, instrValid=0, instrOut/opOut/funcOut=0, pcOut=0, discard flag=0.
REQ-032 Reset mid-request SHALL abandon the outstanding request; an imemAck in the first cycle after release SHALL be ignored (state IDLE).

Structure
REQ-033 Shared package instr_fetch_pkg SHALL hold the state enumeration, PC_STEP=4, and field bounds OP_MSB=31, OP_LSB=26, FUNC_MSB=5, FUNC_LSB=0.
REQ-034 One sub-module pc_counter (PC register: reset load, +4 increment, redirect load) SHALL be used; FSM and output registers stay in instr_fetch.

Verification
REQ-035 Reset release, en=1, ack 2 cycles after each req, instrReady=1 -> imemAddr 0x0,0x4,0x8; opOut/funcOut match rdata fields; pcOut 0x0,0x4,0x8.
REQ-036 Backpressure: instrReady=0 for 5 cycles in HOLD -> all outputs stable, no new imemReq; ready=1 -> next req at PC+4.
REQ-037 pcLoad=1, pcTarget=0x100 during WAIT (ack for 0x8 pending) -> ack data dropped, instrValid=0, next imemAddr=0x100, pcOut=0x100.
REQ-038 pcLoad with instrReady same cycle in HOLD -> instruction accepted once, next request 0x200.
REQ-039 PC=0xFFFF_FFFC fetched -> next imemAddr=0x0.
REQ-040 rst low while imemReq high -> imemReq=0 asynchronously; ack in first cycle after release ignored; fetch restarts at RESET_PC.
